// File: rtl/jrb_regbank_seq_if.sv
// jrb_regbank_seq_if
//
// Purpose: groups the internal data-bus signals and the buffered output-port
// handshake of the jrb register bank into one bundle.
//
// Signals:
//   bus_in    DATA_W  value on the data bus this cycle
//   in_sel    SEL_W   write target (0 none, 1..NUM_REGS reg, NUM_REGS+1 out port)
//   out_sel   SEL_W   bus source   (0 none, 1..NUM_REGS reg)
//   bus_out   DATA_W  selected register value, 0 when bus_oe is low
//   bus_oe    1       out_sel selects a register
//   out_data  DATA_W  head of the output port
//   out_valid 1       out_data is valid
//   out_ready 1       consumer accepts out_data
//   out_full  1       output port cannot take a write this cycle
//   out_ovf   1       sticky: a write to the output port was dropped
//
// Modports:
//   master - control unit / consumer side (drives selects, bus_in, out_ready)
//   slave  - the register bank itself
interface jrb_regbank_seq_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
);
  logic [DATA_W-1:0] bus_in;
  logic [SEL_W-1:0]  in_sel;
  logic [SEL_W-1:0]  out_sel;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_full;
  logic              out_ovf;

  modport master (
    output bus_in, in_sel, out_sel, out_ready,
    input  bus_out, bus_oe, out_data, out_valid, out_full, out_ovf
  );

  modport slave (
    input  bus_in, in_sel, out_sel, out_ready,
    output bus_out, bus_oe, out_data, out_valid, out_full, out_ovf
  );
endinterface

// File: rtl/jrb_regbank_seq.sv
// jrb_regbank_seq
//
// Purpose: register file, program counter and buffered output port of the
// jrb CPU core. Sits between the control unit and the ALU/jump logic and
// drives the internal data bus.
//
// Optional feature macro: JRB_OUT_FIFO_EN
//   undefined : output port is a single-entry holding register
//   defined   : output port is an OUT_DEPTH-entry circular FIFO
//
// Parameters:
//   DATA_W    register / bus / output port width
//   NUM_REGS  number of general registers (1..14)
//   PC_W      program counter width
//   SEL_W     width of in_sel/out_sel, 2**SEL_W >= NUM_REGS+2
//   OUT_DEPTH output FIFO depth (power of 2, >= 2), FIFO build only
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   bus        slave modport of jrb_regbank_seq_if (data bus + output port)
//   reg_b_sel  in   0: reg[1] on reg_b, 1: reg[2] on reg_b (NUM_REGS >= 3)
//   reg_a      out  reg[0], ALU A operand
//   reg_b      out  ALU B operand
//   pc_load    in   load pc_in into the PC (highest priority)
//   pc_in      in   jump target
//   pc_hold    in   freeze the PC
//   pc         out  current program counter
module jrb_regbank_seq #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 4,
  parameter int PC_W      = 16,
  parameter int SEL_W     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  jrb_regbank_seq_if.slave    bus,
  input  logic                reg_b_sel,
  output logic [DATA_W-1:0]   reg_a,
  output logic [DATA_W-1:0]   reg_b,
  input  logic                pc_load,
  input  logic [PC_W-1:0]     pc_in,
  input  logic                pc_hold,
  output logic [PC_W-1:0]     pc
);

  // Elaboration-time parameter sanity checks.
  if ((2 ** SEL_W) < (NUM_REGS + 2)) begin : g_sel_w_chk
    $error("jrb_regbank_seq: SEL_W too narrow for NUM_REGS+2 codes");
  end
  if ((NUM_REGS < 1) || (NUM_REGS > 14)) begin : g_num_regs_chk
    $error("jrb_regbank_seq: NUM_REGS must be 1..14");
  end
  if ((OUT_DEPTH < 2) || ((OUT_DEPTH & (OUT_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("jrb_regbank_seq: OUT_DEPTH must be a power of 2, at least 2");
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // in_sel is decoded against every register index; codes outside
  // 1..NUM_REGS simply match nothing, so at most one register is written.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.in_sel == SEL_W'(i + 1)) begin
        regs_d[i] = bus.bus_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read side works from the registered state only, so a same-cycle write
  // to the selected register shows the old value until the next cycle.
  logic [DATA_W-1:0] bus_out_c;
  logic              bus_oe_c;

  always_comb begin
    bus_out_c = '0;
    bus_oe_c  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.out_sel == SEL_W'(i + 1)) begin
        bus_out_c = regs_q[i];
        bus_oe_c  = 1'b1;
      end
    end
  end

  assign bus.bus_out = bus_out_c;
  assign bus.bus_oe  = bus_oe_c;
  assign reg_a       = regs_q[0];

  if (NUM_REGS >= 3) begin : g_reg_b_mux
    assign reg_b = reg_b_sel ? regs_q[2] : regs_q[1];
  end else if (NUM_REGS == 2) begin : g_reg_b_fixed
    assign reg_b = regs_q[1];
  end else begin : g_reg_b_single
    // Only one register exists; it is the best available B operand.
    assign reg_b = regs_q[0];
  end

  // ---------------------------------------------------------------------
  // Program counter: load > hold > increment (wraps naturally)
  // ---------------------------------------------------------------------
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    if (pc_load) begin
      pc_d = pc_in;
    end else if (pc_hold) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  // ---------------------------------------------------------------------
  // Output port
  // ---------------------------------------------------------------------
  logic push_req;
  logic out_ovf_q;
  logic out_ovf_d;

  assign push_req = (bus.in_sel == SEL_W'(NUM_REGS + 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ovf_q <= 1'b0;
    end else begin
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.out_ovf = out_ovf_q;

`ifdef JRB_OUT_FIFO_EN
  localparam int AW = $clog2(OUT_DEPTH);

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [DATA_W-1:0] mem_d [OUT_DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       wptr_d;
  logic [AW:0]       rptr_q;
  logic [AW:0]       rptr_d;
  logic [AW:0]       count;
  logic              level_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate counter; their difference is the fill level.
  assign count      = wptr_q - rptr_q;
  assign level_full = (count == (AW + 1)'(OUT_DEPTH));
  assign fifo_empty = (wptr_q == rptr_q);
  assign pop        = !fifo_empty && bus.out_ready;
  // When full, a simultaneous pop frees the slot being written: the write
  // slot then aliases the head slot that leaves on the same edge.
  assign accept     = push_req && (!level_full || pop);

  always_comb begin
    for (int i = 0; i < OUT_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (accept) begin
      mem_d[wptr_q[AW-1:0]] = bus.bus_in;
    end
    wptr_d    = wptr_q + {{AW{1'b0}}, accept};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    out_ovf_d = out_ovf_q || (push_req && !accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign bus.out_data  = mem_q[rptr_q[AW-1:0]];
  assign bus.out_valid = !fifo_empty;
  assign bus.out_full  = level_full && !bus.out_ready;
`else
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic              pop;

  assign pop = out_valid_q && bus.out_ready;

  // A write that coincides with a pop replaces the entry and keeps
  // out_valid high; a write while occupied without a pop is dropped.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    if (pop) begin
      out_valid_d = 1'b0;
    end
    if (push_req) begin
      if (!out_valid_q || pop) begin
        out_data_d  = bus.bus_in;
        out_valid_d = 1'b1;
      end else begin
        out_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_full  = out_valid_q && !bus.out_ready;
`endif

endmodule

// File: tb/tb_jrb_regbank_seq.sv
// Self-checking bench for jrb_regbank_seq. A queue-based reference model
// tracks registers, PC and the output port; capacity follows the build
// (1 entry by default, 4 with JRB_OUT_FIFO_EN).
module tb_jrb_regbank_seq;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int PW = 16;
  localparam int SW = 4;
`ifdef JRB_OUT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_b_sel;
  logic [DW-1:0] reg_a;
  logic [DW-1:0] reg_b;
  logic          pc_load;
  logic [PW-1:0] pc_in;
  logic          pc_hold;
  logic [PW-1:0] pc;

  int n_vec = 0;
  int n_err = 0;

  jrb_regbank_seq_if #(.DATA_W(DW), .SEL_W(SW)) bus_if ();

  jrb_regbank_seq #(
    .DATA_W(DW), .NUM_REGS(NR), .PC_W(PW), .SEL_W(SW), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .reg_b_sel(reg_b_sel),
    .reg_a(reg_a), .reg_b(reg_b), .pc_load(pc_load), .pc_in(pc_in),
    .pc_hold(pc_hold), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference model state
  logic [DW-1:0] m_reg [NR];
  logic [PW-1:0] m_pc;
  logic [DW-1:0] m_q [$];
  logic          m_ovf;

  task automatic model_step();
    int sel;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_pc  = '0;
      m_ovf = 1'b0;
      m_q.delete();
    end else begin
      sel = int'(bus_if.in_sel);
      if (sel >= 1 && sel <= NR) m_reg[sel-1] = bus_if.bus_in;
      if (pc_load) m_pc = pc_in;
      else if (!pc_hold) m_pc = m_pc + 1'b1;
      if (m_q.size() > 0 && bus_if.out_ready) void'(m_q.pop_front());
      if (sel == NR + 1) begin
        if (m_q.size() < CAP) m_q.push_back(bus_if.bus_in);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset            = 1'b0;
    bus_if.bus_in    = '0;
    bus_if.in_sel    = '0;
    bus_if.out_sel   = '0;
    bus_if.out_ready = 1'b0;
    reg_b_sel        = 1'b0;
    pc_load          = 1'b0;
    pc_in            = '0;
    pc_hold          = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_vec++; if (pc !== 16'h0) begin n_err++; $display("FAIL rst_pc got %h want 0000", pc); end
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus_if.out_valid); end
    n_vec++; if (bus_if.out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", bus_if.out_ovf); end
    n_vec++; if (bus_if.out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %h want 00", bus_if.out_data); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (pc !== PW'(i)) begin n_err++; $display("FAIL inc_pc[%0d] got %h want %h", i, pc, PW'(i)); end
      tick();
    end
    pc_hold = 1'b1;
    for (int s = 1; s <= NR; s++) begin
      bus_if.out_sel = SW'(s);
      #1;
      n_vec++; if (bus_if.bus_out !== 8'h00) begin n_err++; $display("FAIL rst_reg%0d got %h want 00", s - 1, bus_if.bus_out); end
    end
    n_vec++; if (reg_a !== 8'h00) begin n_err++; $display("FAIL rst_reg_a got %h want 00", reg_a); end
    idle();
  endtask

  task automatic test_reg_path();
    idle();
    pc_hold = 1'b1;
    bus_if.in_sel = SW'(2); bus_if.bus_in = 8'h5A;
    tick();
    bus_if.in_sel = '0; bus_if.out_sel = SW'(2);
    #1;
    n_vec++; if (bus_if.bus_out !== 8'h5A) begin n_err++; $display("FAIL rd_5a got %h want 5a", bus_if.bus_out); end
    n_vec++; if (bus_if.bus_oe !== 1'b1) begin n_err++; $display("FAIL rd_oe got %b want 1", bus_if.bus_oe); end
    bus_if.in_sel = SW'(2); bus_if.bus_in = 8'h33;
    #1;
    n_vec++; if (bus_if.bus_out !== 8'h5A) begin n_err++; $display("FAIL rd_old got %h want 5a", bus_if.bus_out); end
    tick();
    bus_if.in_sel = '0;
    #1;
    n_vec++; if (bus_if.bus_out !== 8'h33) begin n_err++; $display("FAIL rd_new got %h want 33", bus_if.bus_out); end
    n_vec++; if (reg_b !== 8'h33) begin n_err++; $display("FAIL reg_b_r1 got %h want 33", reg_b); end
    bus_if.in_sel = SW'(1); bus_if.bus_in = 8'hC3;
    tick();
    bus_if.in_sel = SW'(3); bus_if.bus_in = 8'h7E;
    tick();
    bus_if.in_sel = '0; reg_b_sel = 1'b1;
    #1;
    n_vec++; if (reg_a !== 8'hC3) begin n_err++; $display("FAIL reg_a got %h want c3", reg_a); end
    n_vec++; if (reg_b !== 8'h7E) begin n_err++; $display("FAIL reg_b_r2 got %h want 7e", reg_b); end
    bus_if.out_sel = SW'(NR + 1);
    #1;
    n_vec++; if (bus_if.bus_oe !== 1'b0 || bus_if.bus_out !== 8'h00) begin
      n_err++; $display("FAIL rd_none oe=%b bus=%h want oe=0 bus=00", bus_if.bus_oe, bus_if.bus_out);
    end
    idle();
  endtask

  task automatic test_pc_control();
    idle();
    pc_load = 1'b1; pc_in = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    #1;
    n_vec++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL pc_load got %h want ffff", pc); end
    tick();
    n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL pc_wrap got %h want 0000", pc); end
    pc_load = 1'b1; pc_hold = 1'b1; pc_in = 16'h1234;
    tick();
    pc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (pc !== 16'h1234) begin n_err++; $display("FAIL pc_hold[%0d] got %h want 1234", i, pc); end
      tick();
    end
    n_vec++; if (pc !== 16'h1234) begin n_err++; $display("FAIL pc_hold_end got %h want 1234", pc); end
    idle();
  endtask

  task automatic test_out_port();
    idle();
    reset = 1'b1;
    tick();
    idle();
    pc_hold = 1'b1;
`ifdef JRB_OUT_FIFO_EN
    for (int k = 1; k <= 4; k++) begin
      bus_if.in_sel = SW'(NR + 1); bus_if.bus_in = DW'(k);
      tick();
    end
    bus_if.in_sel = '0;
    #1;
    n_vec++; if (bus_if.out_full !== 1'b1) begin n_err++; $display("FAIL fifo_full got %b want 1", bus_if.out_full); end
    n_vec++; if (bus_if.out_data !== 8'h01) begin n_err++; $display("FAIL fifo_head got %h want 01", bus_if.out_data); end
    bus_if.in_sel = SW'(NR + 1); bus_if.bus_in = 8'h05; bus_if.out_ready = 1'b1;
    #1;
    n_vec++; if (bus_if.out_full !== 1'b0) begin n_err++; $display("FAIL fifo_full_rdy got %b want 0", bus_if.out_full); end
    tick();
    bus_if.in_sel = '0;
    for (int k = 2; k <= 5; k++) begin
      #1;
      n_vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== DW'(k)) begin
        n_err++; $display("FAIL fifo_drain v=%b d=%h want v=1 d=%h", bus_if.out_valid, bus_if.out_data, DW'(k));
      end
      tick();
    end
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL fifo_empty got %b want 0", bus_if.out_valid); end
    n_vec++; if (bus_if.out_ovf !== 1'b0) begin n_err++; $display("FAIL fifo_ovf got %b want 0", bus_if.out_ovf); end
`else
    bus_if.in_sel = SW'(NR + 1); bus_if.bus_in = 8'h11;
    tick();
    bus_if.bus_in = 8'h22;
    #1;
    n_vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_full !== 1'b1) begin
      n_err++; $display("FAIL ob_held v=%b f=%b want v=1 f=1", bus_if.out_valid, bus_if.out_full);
    end
    tick();
    bus_if.in_sel = '0;
    #1;
    n_vec++; if (bus_if.out_ovf !== 1'b1) begin n_err++; $display("FAIL ob_ovf got %b want 1", bus_if.out_ovf); end
    n_vec++; if (bus_if.out_data !== 8'h11) begin n_err++; $display("FAIL ob_data got %h want 11", bus_if.out_data); end
    bus_if.out_ready = 1'b1;
    #1;
    n_vec++; if (bus_if.out_full !== 1'b0 || bus_if.out_valid !== 1'b1) begin
      n_err++; $display("FAIL ob_rdy f=%b v=%b want f=0 v=1", bus_if.out_full, bus_if.out_valid);
    end
    tick();
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL ob_pop got %b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0; bus_if.in_sel = SW'(NR + 1); bus_if.bus_in = 8'h44;
    tick();
    bus_if.out_ready = 1'b1; bus_if.bus_in = 8'h55;
    tick();
    bus_if.in_sel = '0; bus_if.out_ready = 1'b0;
    #1;
    n_vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'h55) begin
      n_err++; $display("FAIL ob_replace v=%b d=%h want v=1 d=55", bus_if.out_valid, bus_if.out_data);
    end
`endif
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    pc_hold = 1'b1;
    for (int k = 0; k < ((CAP == 1) ? 2 : 3); k++) begin
      bus_if.in_sel = SW'(NR + 1); bus_if.bus_in = DW'(8'hA0 + k);
      tick();
    end
    reset = 1'b1; pc_load = 1'b1; pc_in = 16'hABCD;
    bus_if.in_sel = SW'(1); bus_if.bus_in = 8'hEE; bus_if.out_ready = 1'b1;
    tick();
    idle();
    pc_hold = 1'b1;
    #1;
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", bus_if.out_valid); end
    n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL rm_pc got %h want 0000", pc); end
    n_vec++; if (bus_if.out_ovf !== 1'b0) begin n_err++; $display("FAIL rm_ovf got %b want 0", bus_if.out_ovf); end
    n_vec++; if (reg_a !== 8'h00) begin n_err++; $display("FAIL rm_reg_a got %h want 00", reg_a); end
    idle();
  endtask

  task automatic test_random();
    int os;
    logic [DW-1:0] e_bus;
    logic [DW-1:0] e_b;
    logic          e_oe;
    for (int c = 0; c < 600; c++) begin
      reset            = ($urandom_range(0, 59) == 0);
      bus_if.bus_in    = DW'($urandom);
      bus_if.in_sel    = ($urandom_range(0, 2) == 0) ? SW'(NR + 1) : SW'($urandom_range(0, 15));
      bus_if.out_sel   = SW'($urandom_range(0, 15));
      bus_if.out_ready = ($urandom_range(0, 2) == 0);
      reg_b_sel        = 1'($urandom);
      pc_load          = ($urandom_range(0, 7) == 0);
      pc_hold          = ($urandom_range(0, 3) == 0);
      pc_in            = PW'($urandom);
      #1;
      os    = int'(bus_if.out_sel);
      e_oe  = (os >= 1 && os <= NR);
      e_bus = '0;
      if (e_oe) e_bus = m_reg[os-1];
      e_b   = reg_b_sel ? m_reg[2] : m_reg[1];
      n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got %h want %h", c, pc, m_pc); end
      n_vec++; if (reg_a !== m_reg[0] || reg_b !== e_b) begin
        n_err++; $display("FAIL rnd_ab c=%0d got %h/%h want %h/%h", c, reg_a, reg_b, m_reg[0], e_b);
      end
      n_vec++; if (bus_if.bus_out !== e_bus || bus_if.bus_oe !== e_oe) begin
        n_err++; $display("FAIL rnd_bus c=%0d got %h/%b want %h/%b", c, bus_if.bus_out, bus_if.bus_oe, e_bus, e_oe);
      end
      n_vec++; if (bus_if.out_valid !== (m_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus_if.out_valid, m_q.size() > 0);
      end
      n_vec++; if (bus_if.out_full !== ((m_q.size() == CAP) && !bus_if.out_ready)) begin
        n_err++; $display("FAIL rnd_full c=%0d got %b want %b", c, bus_if.out_full, (m_q.size() == CAP) && !bus_if.out_ready);
      end
      n_vec++; if (bus_if.out_ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, bus_if.out_ovf, m_ovf); end
      if (m_q.size() > 0) begin
        n_vec++; if (bus_if.out_data !== m_q[0]) begin
          n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, bus_if.out_data, m_q[0]);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reg_path();
    test_pc_control();
    test_out_port();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
